opsum_writeback: RTL and testbench

Drains output partial sums from the conv_unit opsum FIFO columns and writes them back to the GLB SRAM. It is the write-side counterpart of the token_engine GLB read path.
- Per pass it visits the active output-channel columns round-robin, one token position at a time.
- For each word it pops one FIFO entry, applies optional ReLU, and issues one full-word GLB write.
- It raises a done pulse when all tokens for all channels are written.

---
 rtl/opsum_writeback_pkg.sv | 32 +++
 rtl/opsum_wb_addr_gen.sv | 95 +++++++++
 rtl/opsum_writeback.sv | 162 ++++++++++++++++
 tb/tb_opsum_writeback.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opsum_writeback_pkg.sv
// rtl/opsum_writeback_pkg.sv - shared types and constants for the opsum writeback path
package opsum_writeback_pkg;

  typedef enum logic [1:0] {
    LAYER_CONV   = 2'd0,
    LAYER_DWCONV = 2'd1,
    LAYER_FC     = 2'd2
  } layer_type_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    POP   = 3'd2,
    WRITE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } wb_state_e;

  localparam logic [3:0] GLB_WEB_IDLE = 4'b1111;
  localparam logic [3:0] GLB_WEB_WORD = 4'b0000;

  // Only the low half of ch*plane survives the 32-bit truncation, so a 32-bit product suffices.
  function automatic logic [31:0] glb_word_addr(input logic [31:0] base,
                                                input logic [31:0] ch,
                                                input logic [31:0] plane,
                                                input logic [31:0] tok);
    logic [31:0] prod;
    prod = ch * plane;
    return base + ((prod + tok) << 2);
  endfunction

endpackage

// File: rtl/opsum_wb_addr_gen.sv
// rtl/opsum_wb_addr_gen.sv - channel/token counters and GLB address generation for writeback
module opsum_wb_addr_gen
  import opsum_writeback_pkg::*;
#(
  parameter int NUM_COL = 32,
  parameter int ADDR_W  = 32,
  parameter int CH_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [7:0]        oc_real_i,
  input  logic [31:0]       tokens_i,
  input  logic [31:0]       plane_words_i,
  output logic [CH_W-1:0]   ch_o,
  output logic [CH_W-1:0]   next_ch_o,
  output logic              last_o,
  output logic              zero_tokens_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [CH_W-1:0]   ch_q, ch_d;
  logic [31:0]       tok_q, tok_d;
  logic [CH_W-1:0]   oc_last_q, oc_last_d;
  logic [31:0]       tokens_q, tokens_d;
  logic [31:0]       plane_q, plane_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [CH_W-1:0] oc_last_clamp;
  logic            ch_wrap;
  logic [CH_W-1:0] next_ch;

  // Channel count 0 behaves as 1, anything above the column count is clamped.
  always_comb begin
    if (oc_real_i == 8'd0) begin
      oc_last_clamp = '0;
    end else if ({24'd0, oc_real_i} > 32'(NUM_COL)) begin
      oc_last_clamp = CH_W'(NUM_COL - 1);
    end else begin
      oc_last_clamp = CH_W'(oc_real_i - 8'd1);
    end
  end

  assign ch_wrap = (ch_q == oc_last_q);
  assign next_ch = ch_wrap ? '0 : ch_q + CH_W'(1);

  always_comb begin
    ch_d      = ch_q;
    tok_d     = tok_q;
    oc_last_d = oc_last_q;
    tokens_d  = tokens_q;
    plane_d   = plane_q;
    base_d    = base_q;
    if (load_i) begin
      ch_d      = '0;
      tok_d     = '0;
      oc_last_d = oc_last_clamp;
      tokens_d  = tokens_i;
      plane_d   = plane_words_i;
      base_d    = base_i;
    end else if (advance_i) begin
      ch_d = next_ch;
      if (ch_wrap) begin
        tok_d = tok_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q      <= '0;
      tok_q     <= '0;
      oc_last_q <= '0;
      tokens_q  <= '0;
      plane_q   <= '0;
      base_q    <= '0;
    end else begin
      ch_q      <= ch_d;
      tok_q     <= tok_d;
      oc_last_q <= oc_last_d;
      tokens_q  <= tokens_d;
      plane_q   <= plane_d;
      base_q    <= base_d;
    end
  end

  assign ch_o          = ch_q;
  assign next_ch_o     = next_ch;
  assign last_o        = ch_wrap && (tok_q == tokens_q - 32'd1);
  assign zero_tokens_o = (tokens_q == 32'd0);
  assign addr_o        = ADDR_W'(glb_word_addr(32'(base_q), 32'(ch_q), plane_q, tok_q));

endmodule

// File: rtl/opsum_writeback.sv
// rtl/opsum_writeback.sv - drains opsum FIFO columns round-robin and writes words back to GLB
module opsum_writeback
  import opsum_writeback_pkg::*;
#(
  parameter int NUM_COL = 32,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_start_i,
  input  logic [ADDR_W-1:0]         opsum_GLB_base_addr_i,
  input  logic [7:0]                OC_real_i,
  input  logic [31:0]               tokens_i,
  input  logic [31:0]               plane_words_i,
  input  logic                      relu_en_i,
  input  logic [NUM_COL-1:0]        opsum_fifo_empty_matrix_i,
  input  logic [NUM_COL*DATA_W-1:0] opsum_fifo_pop_data_matrix_i,
  output logic [NUM_COL-1:0]        opsum_fifo_pop_matrix_o,
  output logic [3:0]                glb_web_o,
  output logic [ADDR_W-1:0]         glb_addr_o,
  output logic [DATA_W-1:0]         glb_write_data_o,
  output logic                      wb_busy_o,
  output logic                      wb_done_o
);

  localparam int CH_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;

  wb_state_e           state_q, state_d;
  logic [NUM_COL-1:0]  pop_q, pop_d;
  logic [3:0]          web_q, web_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                relu_q, relu_d;

  logic                load;
  logic                advance;
  logic [CH_W-1:0]     wb_ch;
  logic [CH_W-1:0]     wb_next_ch;
  logic                wb_last;
  logic                wb_zero_tok;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   head;
  logic [DATA_W-1:0]   head_relu;

  assign load    = (state_q == IDLE) && wb_start_i;
  assign advance = (state_q == NEXT);

  opsum_wb_addr_gen #(
    .NUM_COL (NUM_COL),
    .ADDR_W  (ADDR_W),
    .CH_W    (CH_W)
  ) u_addr_gen (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load),
    .advance_i     (advance),
    .base_i        (opsum_GLB_base_addr_i),
    .oc_real_i     (OC_real_i),
    .tokens_i      (tokens_i),
    .plane_words_i (plane_words_i),
    .ch_o          (wb_ch),
    .next_ch_o     (wb_next_ch),
    .last_o        (wb_last),
    .zero_tokens_o (wb_zero_tok),
    .addr_o        (wb_addr)
  );

  assign head      = opsum_fifo_pop_data_matrix_i[32'(wb_ch)*DATA_W +: DATA_W];
  assign head_relu = (relu_q && head[DATA_W-1]) ? '0 : head;

  // NEXT jumps straight to POP when the next column already has data, giving 3 cycles per word.
  always_comb begin
    state_d = state_q;
    pop_d   = '0;
    web_d   = GLB_WEB_IDLE;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    relu_d  = relu_q;
    case (state_q)
      IDLE: begin
        if (wb_start_i) begin
          state_d = WAIT;
          busy_d  = 1'b1;
          relu_d  = relu_en_i;
        end
      end
      WAIT: begin
        if (wb_zero_tok) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!opsum_fifo_empty_matrix_i[wb_ch]) begin
          state_d      = POP;
          pop_d[wb_ch] = 1'b1;
        end
      end
      POP: begin
        state_d = WRITE;
      end
      WRITE: begin
        wdata_d = head_relu;
        web_d   = GLB_WEB_WORD;
        addr_d  = wb_addr;
        state_d = NEXT;
      end
      NEXT: begin
        if (wb_last) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!opsum_fifo_empty_matrix_i[wb_next_ch]) begin
          state_d           = POP;
          pop_d[wb_next_ch] = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pop_q   <= '0;
      web_q   <= GLB_WEB_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pop_q   <= pop_d;
      web_q   <= web_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      relu_q  <= relu_d;
    end
  end

  assign opsum_fifo_pop_matrix_o = pop_q;
  assign glb_web_o               = web_q;
  assign glb_addr_o              = addr_q;
  assign glb_write_data_o        = wdata_q;
  assign wb_busy_o               = busy_q;
  assign wb_done_o               = done_q;

endmodule

// File: tb/tb_opsum_writeback.sv
// tb/tb_opsum_writeback.sv - directed self-checking bench for opsum_writeback
module tb_opsum_writeback;

  logic          clk;
  logic          rst;
  logic          wb_start_i;
  logic [31:0]   base_i;
  logic [7:0]    oc_i;
  logic [31:0]   tokens_i;
  logic [31:0]   plane_i;
  logic          relu_i;
  logic [31:0]   empty_mat;
  logic [1023:0] data_mat;
  logic [31:0]   pop_o;
  logic [3:0]    web_o;
  logic [31:0]   addr_o;
  logic [31:0]   wdata_o;
  logic          busy_o;
  logic          done_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] fifo_mem [32][8];
  int          wr_cnt [32];
  int          rd_ptr [32];
  logic [31:0] hold_empty;
  logic        fifo_clr;

  int          cyc = 0;
  int          n_wr = 0;
  int          n_done = 0;
  int          n_pop = 0;
  int          multi_pop = 0;
  int          pop_col_cnt [32];
  logic [31:0] log_addr [256];
  logic [31:0] log_data [256];
  int          log_cyc [256];

  opsum_writeback #(.NUM_COL(32), .DATA_W(32), .ADDR_W(32)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .wb_start_i                   (wb_start_i),
    .opsum_GLB_base_addr_i        (base_i),
    .OC_real_i                    (oc_i),
    .tokens_i                     (tokens_i),
    .plane_words_i                (plane_i),
    .relu_en_i                    (relu_i),
    .opsum_fifo_empty_matrix_i    (empty_mat),
    .opsum_fifo_pop_data_matrix_i (data_mat),
    .opsum_fifo_pop_matrix_o      (pop_o),
    .glb_web_o                    (web_o),
    .glb_addr_o                   (addr_o),
    .glb_write_data_o             (wdata_o),
    .wb_busy_o                    (busy_o),
    .wb_done_o                    (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    empty_mat = '0;
    for (int c = 0; c < 32; c++) begin
      empty_mat[c] = (rd_ptr[c] >= wr_cnt[c]) || hold_empty[c];
    end
  end

  // FIFO model with one-cycle pop latency plus a write/pop/done monitor.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int c = 0; c < 32; c++) begin
      if (fifo_clr) begin
        rd_ptr[c] = 0;
      end else if (pop_o[c]) begin
        data_mat[c*32 +: 32] = fifo_mem[c][rd_ptr[c] % 8];
        rd_ptr[c] = rd_ptr[c] + 1;
        pop_col_cnt[c] = pop_col_cnt[c] + 1;
      end
    end
    if ($countones(pop_o) > 1) multi_pop = multi_pop + 1;
    if (pop_o != 32'd0) n_pop = n_pop + 1;
    if (web_o == 4'b0000) begin
      log_addr[n_wr % 256] = addr_o;
      log_data[n_wr % 256] = wdata_o;
      log_cyc[n_wr % 256]  = cyc;
      n_wr = n_wr + 1;
    end
    if (done_o) n_done = n_done + 1;
  end

  task automatic fifo_clear();
    fifo_clr = 1'b1;
    @(negedge clk);
    #1;
    for (int c = 0; c < 32; c++) wr_cnt[c] = 0;
    fifo_clr   = 1'b0;
    hold_empty = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [31:0] v);
    fifo_mem[c][wr_cnt[c] % 8] = v;
    wr_cnt[c] = wr_cnt[c] + 1;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [7:0] oc, input logic [31:0] tok,
                          input logic [31:0] plane, input logic relu);
    base_i     = base;
    oc_i       = oc;
    tokens_i   = tok;
    plane_i    = plane;
    relu_i     = relu;
    wb_start_i = 1'b1;
    @(posedge clk);
    #1;
    wb_start_i = 1'b0;
    base_i     = 32'hDEAD_0000;
    oc_i       = 8'd5;
    tokens_i   = 32'd99;
    plane_i    = 32'd7;
    relu_i     = ~relu;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pop_o !== 32'd0 || web_o !== 4'b1111 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: pop=%h web=%b busy=%b done=%b required pop=0 web=1111 busy=0 done=0",
               pop_o, web_o, busy_o, done_o);
    end
    checks++;
    if (addr_o !== 32'd0 || wdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%h data=%h required 0/0", addr_o, wdata_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_pass();
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    int b, d0;
    bit ok;
    ea = '{32'h100, 32'h200, 32'h104, 32'h204};
    ed = '{32'h11, 32'h21, 32'h12, 32'h22};
    fifo_clear();
    push(0, 32'h11); push(0, 32'h12);
    push(1, 32'h21); push(1, 32'h22);
    b = n_wr; d0 = n_done;
    do_start(32'h100, 8'd2, 32'd2, 32'h40, 1'b0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b required 1", busy_o);
    end
    repeat (4) @(posedge clk);
    #1;
    wb_start_i = 1'b1;
    tokens_i   = 32'd1;
    @(posedge clk);
    #1;
    wb_start_i = 1'b0;
    wait_done(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: done=0 required 1 within 200 cycles");
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (n_wr - b !== 4) begin
      errors++;
      $display("FAIL basic_write_count: writes=%0d required 4", n_wr - b);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[b+i] !== ea[i] || log_data[b+i] !== ed[i]) begin
        errors++;
        $display("FAIL basic_write%0d: addr=%h data=%h required addr=%h data=%h",
                 i, log_addr[b+i], log_data[b+i], ea[i], ed[i]);
      end
    end
    checks++;
    if (log_cyc[b+1] - log_cyc[b] !== 3 || log_cyc[b+3] - log_cyc[b+2] !== 3) begin
      errors++;
      $display("FAIL basic_throughput: gaps=%0d,%0d required 3,3",
               log_cyc[b+1] - log_cyc[b], log_cyc[b+3] - log_cyc[b+2]);
    end
    checks++;
    if (n_done - d0 !== 1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done_pulses=%0d busy=%b required 1 and 0", n_done - d0, busy_o);
    end
  endtask

  task automatic test_relu();
    int b, p1;
    bit ok;
    fifo_clear();
    push(0, 32'hFFFF_FFF0); push(0, 32'h0000_0005);
    b = n_wr; p1 = pop_col_cnt[1];
    do_start(32'h0, 8'd0, 32'd2, 32'h0, 1'b1);
    wait_done(100, ok);
    checks++;
    if (!ok || n_wr - b !== 2) begin
      errors++;
      $display("FAIL relu_on_count: done=%b writes=%0d required 1 and 2", ok, n_wr - b);
    end
    checks++;
    if (log_data[b] !== 32'h0 || log_data[b+1] !== 32'h5 || log_addr[b] !== 32'h0 || log_addr[b+1] !== 32'h4) begin
      errors++;
      $display("FAIL relu_on_data: data=%h,%h addr=%h,%h required 0,5 at 0,4",
               log_data[b], log_data[b+1], log_addr[b], log_addr[b+1]);
    end
    checks++;
    if (pop_col_cnt[1] - p1 !== 0) begin
      errors++;
      $display("FAIL oc_zero_pops: col1_pops=%0d required 0", pop_col_cnt[1] - p1);
    end
    fifo_clear();
    push(0, 32'hFFFF_FFF0);
    b = n_wr;
    do_start(32'h0, 8'd1, 32'd1, 32'h0, 1'b0);
    wait_done(100, ok);
    checks++;
    if (!ok || n_wr - b !== 1 || log_data[b] !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL relu_off: done=%b writes=%0d data=%h required 1,1,fffffff0", ok, n_wr - b, log_data[b]);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    int b, bad;
    bit ok, seen;
    ea = '{32'h1000, 32'h1040, 32'h1004, 32'h1044};
    ed = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
    fifo_clear();
    push(0, 32'hA0); push(0, 32'hA1);
    push(1, 32'hB0); push(1, 32'hB1);
    hold_empty[1] = 1'b1;
    b = n_wr;
    do_start(32'h1000, 8'd2, 32'd2, 32'h10, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (n_wr > b) seen = 1'b1;
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (pop_o !== 32'd0 || web_o !== 4'b1111 || busy_o !== 1'b1) bad++;
    end
    checks++;
    if (!seen || bad !== 0 || n_wr - b !== 1) begin
      errors++;
      $display("FAIL stall_hold: first_write=%b bad_cycles=%0d writes=%0d required 1,0,1", seen, bad, n_wr - b);
    end
    hold_empty[1] = 1'b0;
    wait_done(100, ok);
    checks++;
    if (!ok || n_wr - b !== 4) begin
      errors++;
      $display("FAIL stall_finish: done=%b writes=%0d required 1 and 4", ok, n_wr - b);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (log_addr[b+i] !== ea[i] || log_data[b+i] !== ed[i]) begin
        errors++;
        $display("FAIL stall_write%0d: addr=%h data=%h required addr=%h data=%h",
                 i, log_addr[b+i], log_data[b+i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    int b, d0, np, w_at;
    bit ok;
    ea = '{32'h200, 32'h210, 32'h204, 32'h214};
    ed = '{32'h31, 32'h41, 32'h32, 32'h42};
    fifo_clear();
    push(0, 32'h1); push(0, 32'h2);
    push(1, 32'h3); push(1, 32'h4);
    d0 = n_done;
    do_start(32'h200, 8'd2, 32'd2, 32'h4, 1'b0);
    np = 0;
    for (int i = 0; i < 100 && np < 3; i++) begin
      @(posedge clk);
      #1;
      if (pop_o != 32'd0) np++;
    end
    checks++;
    if (np !== 3) begin
      errors++;
      $display("FAIL rstmid_reach: pops=%0d required 3", np);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pop_o !== 32'd0 || web_o !== 4'b1111 || addr_o !== 32'd0 || wdata_o !== 32'd0 ||
        busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: pop=%h web=%b addr=%h data=%h busy=%b done=%b required all reset values",
               pop_o, web_o, addr_o, wdata_o, busy_o, done_o);
    end
    rst = 1'b0;
    w_at = n_wr;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_wr !== w_at || n_done !== d0) begin
      errors++;
      $display("FAIL rstmid_quiet: writes=%0d done=%0d required 0 and 0", n_wr - w_at, n_done - d0);
    end
    fifo_clear();
    push(0, 32'h31); push(0, 32'h32);
    push(1, 32'h41); push(1, 32'h42);
    b = n_wr;
    do_start(32'h200, 8'd2, 32'd2, 32'h4, 1'b0);
    wait_done(200, ok);
    checks++;
    if (!ok || n_wr - b !== 4) begin
      errors++;
      $display("FAIL rstmid_restart: done=%b writes=%0d required 1 and 4", ok, n_wr - b);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[b+i] !== ea[i] || log_data[b+i] !== ed[i]) begin
        errors++;
        $display("FAIL rstmid_write%0d: addr=%h data=%h required addr=%h data=%h",
                 i, log_addr[b+i], log_data[b+i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_zero_tokens();
    int b, p0, d0;
    fifo_clear();
    push(0, 32'h77);
    b = n_wr; p0 = n_pop; d0 = n_done;
    base_i     = 32'h0;
    oc_i       = 8'd3;
    tokens_i   = 32'd0;
    plane_i    = 32'd1;
    relu_i     = 1'b0;
    wb_start_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_wait: busy=%b done=%b required 1 and 0", busy_o, done_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b required 1 and 0", done_o, busy_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_start_on_done: busy=%b done=%b required 0 and 0", busy_o, done_o);
    end
    wb_start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (n_wr !== b || n_pop !== p0 || n_done - d0 !== 1) begin
      errors++;
      $display("FAIL zero_totals: writes=%0d pops=%0d dones=%0d required 0,0,1", n_wr - b, n_pop - p0, n_done - d0);
    end
  endtask

  task automatic test_clamp();
    int b, p_before [32], badcol, mp0;
    bit ok;
    fifo_clear();
    for (int c = 0; c < 32; c++) begin
      push(c, 32'(c));
      push(c, 32'h100 + 32'(c));
      p_before[c] = pop_col_cnt[c];
    end
    b = n_wr; mp0 = multi_pop;
    do_start(32'h0, 8'd40, 32'd2, 32'd1, 1'b0);
    wait_done(1000, ok);
    checks++;
    if (!ok || n_wr - b !== 64) begin
      errors++;
      $display("FAIL clamp_count: done=%b writes=%0d required 1 and 64", ok, n_wr - b);
    end
    badcol = 0;
    for (int c = 0; c < 32; c++) if (pop_col_cnt[c] - p_before[c] != 2) badcol++;
    checks++;
    if (badcol !== 0 || multi_pop !== mp0) begin
      errors++;
      $display("FAIL clamp_pops: bad_columns=%0d multi_hot=%0d required 0 and 0", badcol, multi_pop - mp0);
    end
    checks++;
    if (log_addr[b+31] !== 32'h7C || log_data[b+31] !== 32'd31 ||
        log_addr[b+32] !== 32'h4 || log_data[b+32] !== 32'h100 ||
        log_addr[b+63] !== 32'h80 || log_data[b+63] !== 32'h11F) begin
      errors++;
      $display("FAIL clamp_order: w31=%h/%h w32=%h/%h w63=%h/%h required 7c/1f 4/100 80/11f",
               log_addr[b+31], log_data[b+31], log_addr[b+32], log_data[b+32], log_addr[b+63], log_data[b+63]);
    end
  endtask

  initial begin
    rst        = 1'b1;
    wb_start_i = 1'b0;
    base_i     = '0;
    oc_i       = '0;
    tokens_i   = '0;
    plane_i    = '0;
    relu_i     = 1'b0;
    hold_empty = '0;
    fifo_clr   = 1'b0;
    data_mat   = '0;
    for (int c = 0; c < 32; c++) begin
      wr_cnt[c]      = 0;
      rd_ptr[c]      = 0;
      pop_col_cnt[c] = 0;
      for (int k = 0; k < 8; k++) fifo_mem[c][k] = '0;
    end
    test_reset();
    test_basic_pass();
    test_relu();
    test_stall();
    test_reset_mid();
    test_zero_tokens();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
